// File: rtl/hex_byte_tx.sv
// hex_byte_tx: formats a raw byte stream as an ASCII hex dump ("xx xx ...\r\n") for the USB CDC uplink.
// Optional HEX_TX_LINE_NUMBER_EN prefixes each line with the 4-digit hex byte offset followed by ": ".
module hex_byte_tx #(
   parameter int BYTES_PER_LINE = 16,
   parameter bit UPPERCASE      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic [15:0] byte_count
);

   typedef enum logic [3:0] {
      IDLE, HI, LO, SEP, CR, LF
`ifdef HEX_TX_LINE_NUMBER_EN
      , NUM3, NUM2, NUM1, NUM0, COLON, SPACE
`endif
   } state_e;

   localparam logic [7:0] LastCol = 8'(BYTES_PER_LINE - 1);

   state_e      state_q, state_d;
   logic [7:0]  col_q, col_d;
   logic        flushPending_q, flushPending_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] count_q, count_d;
`ifdef HEX_TX_LINE_NUMBER_EN
   logic [15:0] lineOffset_q, lineOffset_d;
`endif
   logic        inXfer;
   logic        outXfer;

   function automatic logic [7:0] hexChar(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nib};
   endfunction

   assign inXfer     = in_valid && in_ready;
   assign outXfer    = out_valid && out_ready;
   assign byte_count = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         col_q          <= 8'd0;
         flushPending_q <= 1'b0;
         data_q         <= 8'd0;
         count_q        <= 16'd0;
`ifdef HEX_TX_LINE_NUMBER_EN
         lineOffset_q   <= 16'd0;
`endif
      end else begin
         state_q        <= state_d;
         col_q          <= col_d;
         flushPending_q <= flushPending_d;
         data_q         <= data_d;
         count_q        <= count_d;
`ifdef HEX_TX_LINE_NUMBER_EN
         lineOffset_q   <= lineOffset_d;
`endif
      end
   end

   // A flush pulse always latches; it is only acted on from IDLE so a hex pair is never split.
   always_comb begin
      state_d        = state_q;
      col_d          = col_q;
      flushPending_d = flushPending_q | flush;
      data_d         = data_q;
      count_d        = count_q;
`ifdef HEX_TX_LINE_NUMBER_EN
      lineOffset_d   = lineOffset_q;
`endif
      case (state_q)
         IDLE: begin
            if (flushPending_q) begin
               if (col_q != 8'd0) begin
                  state_d = CR;
                  col_d   = 8'd0;
               end else begin
                  flushPending_d = flush;
               end
            end else if (inXfer) begin
               data_d  = in_data;
               count_d = count_q + 16'd1;
`ifdef HEX_TX_LINE_NUMBER_EN
               lineOffset_d = count_q;
               state_d      = (col_q == 8'd0) ? NUM3 : HI;
`else
               state_d = HI;
`endif
            end
         end
         HI:  if (outXfer) state_d = LO;
         LO: begin
            if (outXfer) begin
               if (col_q == LastCol) begin
                  col_d   = 8'd0;
                  state_d = CR;
               end else begin
                  col_d   = col_q + 8'd1;
                  state_d = SEP;
               end
            end
         end
         SEP: if (outXfer) state_d = IDLE;
         CR:  if (outXfer) state_d = LF;
         LF: begin
            if (outXfer) begin
               state_d        = IDLE;
               flushPending_d = flush;
            end
         end
`ifdef HEX_TX_LINE_NUMBER_EN
         NUM3:  if (outXfer) state_d = NUM2;
         NUM2:  if (outXfer) state_d = NUM1;
         NUM1:  if (outXfer) state_d = NUM0;
         NUM0:  if (outXfer) state_d = COLON;
         COLON: if (outXfer) state_d = SPACE;
         SPACE: if (outXfer) state_d = HI;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q != IDLE);
      in_ready  = !reset && (state_q == IDLE) && !flushPending_q;
      busy      = (state_q != IDLE) || flushPending_q;
      out_data  = 8'h00;
      case (state_q)
         HI:  out_data = hexChar(data_q[7:4]);
         LO:  out_data = hexChar(data_q[3:0]);
         SEP: out_data = 8'h20;
         CR:  out_data = 8'h0D;
         LF:  out_data = 8'h0A;
`ifdef HEX_TX_LINE_NUMBER_EN
         NUM3:  out_data = hexChar(lineOffset_q[15:12]);
         NUM2:  out_data = hexChar(lineOffset_q[11:8]);
         NUM1:  out_data = hexChar(lineOffset_q[7:4]);
         NUM0:  out_data = hexChar(lineOffset_q[3:0]);
         COLON: out_data = 8'h3A;
         SPACE: out_data = 8'h20;
`endif
         default: out_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_hex_byte_tx.sv
// Testbench for hex_byte_tx: a character-queue model predicts the output stream and handshakes every cycle,
// and literal strings pin the expected text of each directed scenario.
module tb_hex_byte_tx;

   localparam int BPL   = 4;
   localparam bit UPPER = 1'b1;
`ifdef HEX_TX_LINE_NUMBER_EN
   localparam int PRE = 6;
`else
   localparam int PRE = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        busy;
   logic [15:0] byte_count;

   int checks = 0;
   int errors = 0;

   // Model state: characters still owed to the sink, column, pending flush, byte counter.
   logic [7:0]  mq[$];
   logic [7:0]  cap[$];
   int          mCol = 0;
   bit          mPend = 1'b0;
   logic [15:0] mCnt = 16'd0;
   bit          started = 1'b0;

   hex_byte_tx #(.BYTES_PER_LINE(BPL), .UPPERCASE(UPPER)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic checkStr(input string name, input string exp);
      string act = "";
      string expHex = "";
      bit ok;
      ok = (cap.size() == exp.len());
      foreach (cap[i]) begin
         act = {act, $sformatf("%02h ", cap[i])};
         if (ok && cap[i] != exp[i]) ok = 1'b0;
      end
      for (int i = 0; i < exp.len(); i++) expHex = {expHex, $sformatf("%02h ", exp[i])};
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got [%s] expected [%s]", name, act, expHex);
      end
      cap.delete();
   endtask

   function automatic logic [7:0] hexc(input int n);
      if (n < 10) return 8'(48 + n);
      return 8'((UPPER ? 55 : 87) + n);
   endfunction

   task automatic pushByte(input logic [7:0] b);
`ifdef HEX_TX_LINE_NUMBER_EN
      if (mCol == 0) begin
         for (int s = 12; s >= 0; s -= 4) mq.push_back(hexc(int'(mCnt >> s) & 15));
         mq.push_back(8'h3A);
         mq.push_back(8'h20);
      end
`endif
      mq.push_back(hexc(int'(b[7:4])));
      mq.push_back(hexc(int'(b[3:0])));
      mCol++;
      if (mCol == BPL) begin
         mq.push_back(8'h0D);
         mq.push_back(8'h0A);
         mCol = 0;
      end else begin
         mq.push_back(8'h20);
      end
   endtask

   // Compare process: check outputs against the model, then advance the model across the coming edge.
   initial begin : compare
      bit newPend;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready && !reset) cap.push_back(out_data);
         if (reset) begin
            checkOutput("in_ready_during_reset", in_ready, 0);
            mq.delete();
            mCol = 0; mPend = 1'b0; mCnt = 16'd0; started = 1'b1;
         end else if (started) begin
            checkOutput("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) checkOutput("out_data", out_data, mq[0]);
            checkOutput("in_ready", in_ready, (mq.size() == 0) && !mPend);
            checkOutput("busy", busy, (mq.size() != 0) || mPend);
            checkOutput("byte_count", byte_count, mCnt);
            newPend = mPend;
            if (mq.size() != 0) begin
               if (out_ready) begin
                  if (mq[0] == 8'h0A) newPend = 1'b0;
                  void'(mq.pop_front());
               end
            end else if (mPend) begin
               if (mCol != 0) begin
                  mq.push_back(8'h0D);
                  mq.push_back(8'h0A);
                  mCol = 0;
               end else begin
                  newPend = 1'b0;
               end
            end else if (in_valid) begin
               pushByte(in_data);
               mCnt = mCnt + 16'd1;
            end
            if (flush) newPend = 1'b1;
            mPend = newPend;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic f);
      bit got;
      in_data = b; in_valid = 1'b1; flush = f;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         got = in_ready;
         tick();
         flush = 1'b0;
         if (got) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: byte %02h never accepted", b);
   endtask

   task automatic pulseFlush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (mq.size() == 0 && !mPend) return;
         tick();
      end
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: %0d chars outstanding", mq.size());
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic pat[4];
      int   busyCycles;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      tick();
      tick();
      reset = 1'b0;
      tick();
      cap.delete();

      $display("[TB] single byte");
      applyStimulus(8'hA5, 1'b0);
      drain();
`ifdef HEX_TX_LINE_NUMBER_EN
      checkStr("single_byte", "0000: A5 ");
`else
      checkStr("single_byte", "A5 ");
`endif
      checkOutput("count_after_single", byte_count, 16'd1);

      $display("[TB] flush partial line");
      pulseFlush();
      drain();
      checkStr("flush_partial", "\r\n");

      $display("[TB] full line");
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'hFE, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      drain();
`ifdef HEX_TX_LINE_NUMBER_EN
      checkStr("full_line", "0001: 00 01 FE FF\r\n");
`else
      checkStr("full_line", "00 01 FE FF\r\n");
`endif
      checkOutput("count_after_line", byte_count, 16'd5);

      $display("[TB] back-pressure");
      applyStimulus(8'h3C, 1'b0);
      foreach (pat[i]) begin
         out_ready = pat[i];
         tick();
      end
      out_ready = 1'b1;
      drain();
`ifdef HEX_TX_LINE_NUMBER_EN
      checkStr("backpressure", "0005: 3C ");
`else
      checkStr("backpressure", "3C ");
`endif

      $display("[TB] flush with simultaneous byte");
      applyStimulus(8'h12, 1'b0);
      drain();
      applyStimulus(8'h34, 1'b1);
      drain();
      checkStr("flush_with_byte", "12 34 \r\n");

      $display("[TB] flush at column zero");
      pulseFlush();
      busyCycles = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy) busyCycles++;
         tick();
      end
      checkOutput("flush_col0_busy_cycles", busyCycles, 1);
      checkStr("flush_col0_no_output", "");

      $display("[TB] reset mid-pair");
      applyStimulus(8'h5A, 1'b0);
      repeat (PRE + 1) tick();
      checkOutput("lo_char_before_reset", out_data, 8'h41);
      reset = 1'b1;
      tick();
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_byte_count", byte_count, 16'd0);
      reset = 1'b0;
      #1;
      checkOutput("reset_in_ready", in_ready, 1);
      tick();
      cap.delete();

      $display("[TB] five bytes after reset");
      for (int i = 0; i < 5; i++) applyStimulus(8'hAA, 1'b0);
      drain();
`ifdef HEX_TX_LINE_NUMBER_EN
      checkStr("five_bytes", "0000: AA AA AA AA\r\n0004: AA ");
`else
      checkStr("five_bytes", "AA AA AA AA\r\nAA ");
`endif
      checkOutput("count_after_five", byte_count, 16'd5);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
